// File: rtl/count_sequencer.sv
// ---------------------------------------------------------------------------
// count_sequencer
//
// Start/stop/hold controlled up-counter with one-shot or auto-restart modes.
// A sequence counts 0..limit_q, pulses done for one cycle on reaching the
// terminal value, then either parks in DONE (one-shot) or wraps to 0 and keeps
// running (periodic). limit and periodic are captured only on an accepted
// start, so they may change freely while a sequence is in progress.
//
// Parameters
//   NBITS     counter width in bits
//
// Ports
//   clk       clock, rising edge active
//   rst       asynchronous active-low reset
//   start     level request to begin a sequence (IDLE or DONE only)
//   stop      level abort back to IDLE, highest priority
//   hold      level pause of a running sequence
//   periodic  1 = auto-restart at limit, 0 = one-shot; sampled with start
//   limit     terminal count; sampled with start
//   count     registered counter value
//   cnt_ena   combinational strobe: count advances/wraps on the next edge
//   busy      high in RUN or HOLD
//   done      registered one-cycle terminal-count pulse
//   state     encoded FSM state (IDLE=00, RUN=01, HOLD=10, DONE=11)
// ---------------------------------------------------------------------------
module count_sequencer #(
    parameter int unsigned NBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             periodic,
    input  logic [NBITS-1:0] limit,
    output logic [NBITS-1:0] count,
    output logic             cnt_ena,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StRun  = 2'b01;
    localparam logic [1:0] StHold = 2'b10;
    localparam logic [1:0] StDone = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [NBITS-1:0] count_q, count_d;
    logic [NBITS-1:0] limit_q, limit_d;
    logic             mode_q,  mode_d;
    logic             done_q,  done_d;

    logic             at_limit;

    assign at_limit = (count_q == limit_q);
    assign cnt_ena  = (state_q == StRun) && !hold && !stop;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        if (stop) begin
            // Abort wins over start, hold and terminal count in every state.
            state_d = StIdle;
            count_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StRun;
                        count_d = '0;
                        limit_d = limit;
                        mode_d  = periodic;
                    end
                end
                StRun: begin
                    if (hold) begin
                        state_d = StHold;
                    end else if (at_limit) begin
                        done_d = 1'b1;
                        if (mode_q) begin
                            count_d = '0;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                StHold: begin
                    // The release edge only re-enters RUN; counting resumes after.
                    if (!hold) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;
    assign state = state_q;
    assign busy  = (state_q == StRun) || (state_q == StHold);

endmodule

// File: tb/tb_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_count_sequencer
//
// Bench for count_sequencer. A driver applies inputs on the falling edge,
// advances a behavioural model and queues the outputs expected after the next
// rising edge; a monitor pops and compares after every rising edge. cnt_ena is
// combinational and is compared by the driver just after applying inputs.
// ---------------------------------------------------------------------------
module tb_count_sequencer;

    localparam int NB = 4;

    // Model phases, numbered by the output code each phase must report.
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_HOLD = 2;
    localparam int P_DONE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          hold = 1'b0;
    logic          periodic = 1'b0;
    logic [NB-1:0] limit = '0;
    logic [NB-1:0] count;
    logic          cnt_ena;
    logic          busy;
    logic          done;
    logic [1:0]    state;

    count_sequencer #(.NBITS(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .periodic (periodic),
        .limit    (limit),
        .count    (count),
        .cnt_ena  (cnt_ena),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int st;
        int dn;
        int bsy;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Behavioural model
    int m_phase = P_IDLE;
    int m_cnt   = 0;
    int m_lim   = 0;
    int m_per   = 0;
    int m_done  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_cnt   = 0;
        m_lim   = 0;
        m_per   = 0;
        m_done  = 0;
    endtask

    task automatic model_step(input int st, input int sp, input int hd, input int per,
                              input int lim);
        m_done = 0;
        if (sp != 0) begin
            m_phase = P_IDLE;
            m_cnt   = 0;
        end else if (m_phase == P_IDLE || m_phase == P_DONE) begin
            if (st != 0) begin
                m_phase = P_RUN;
                m_cnt   = 0;
                m_lim   = lim;
                m_per   = per;
            end
        end else if (m_phase == P_RUN) begin
            if (hd != 0) begin
                m_phase = P_HOLD;
            end else if (m_cnt == m_lim) begin
                m_done = 1;
                if (m_per != 0) m_cnt = 0;
                else            m_phase = P_DONE;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            if (hd == 0) m_phase = P_RUN;
        end
    endtask

    // One clock cycle of stimulus: r is the reset level for this cycle.
    task automatic cycle(input int r, input int st, input int sp, input int hd, input int per,
                         input int lim);
        exp_t e;
        int   exp_ena;
        @(negedge clk);
        rst      = (r != 0);
        start    = (st != 0);
        stop     = (sp != 0);
        hold     = (hd != 0);
        periodic = (per != 0);
        limit    = NB'(lim);
        if (r == 0) model_reset();
        exp_ena = (m_phase == P_RUN && hd == 0 && sp == 0 && r != 0) ? 1 : 0;
        #1;
        check("cnt_ena", int'(cnt_ena), exp_ena);
        if (r != 0) model_step(st, sp, hd, per, lim);
        e.cnt = m_cnt;
        e.st  = m_phase;
        e.dn  = m_done;
        e.bsy = (m_phase == P_RUN || m_phase == P_HOLD) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n, input int lim);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, lim);
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic async_reset(input int hold_cycles);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_count", int'(count), 0);
        check("rst_state", int'(state), P_IDLE);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cnt_ena", int'(cnt_ena), 0);
        for (int i = 0; i < hold_cycles; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents registered outputs after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count", int'(count), e.cnt);
                check("state", int'(state), e.st);
                check("done", int'(done), e.dn);
                check("busy", int'(busy), e.bsy);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st, sp, hd, per, lim, r;

        // Reset state
        #3;
        check("init_count", int'(count), 0);
        check("init_state", int'(state), P_IDLE);
        check("init_busy", int'(busy), 0);
        check("init_cnt_ena", int'(cnt_ena), 0);
        for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 1, 7);
        idle_cycles(2, 0);

        // One-shot, limit 5
        cycle(1, 1, 0, 0, 0, 5);
        idle_cycles(9, 5);

        // Periodic, limit 3
        cycle(1, 1, 0, 0, 1, 3);
        idle_cycles(12, 3);
        cycle(1, 0, 1, 0, 0, 3);

        // Hold at count 4 for 3 cycles, limit 9
        cycle(1, 1, 0, 0, 0, 9);
        idle_cycles(4, 9);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0, 9);
        idle_cycles(9, 9);

        // Stop priority: start+stop in IDLE, then stop at count 7
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 12);
        idle_cycles(2, 0);
        cycle(1, 1, 0, 0, 0, 12);
        idle_cycles(7, 12);
        cycle(1, 0, 1, 0, 0, 12);
        idle_cycles(2, 12);

        // Boundaries: limit 0 one-shot, limit 0 periodic, limit 15 periodic
        cycle(1, 1, 0, 0, 0, 0);
        idle_cycles(3, 0);
        cycle(1, 1, 0, 0, 1, 0);
        idle_cycles(4, 0);
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 1, 15);
        idle_cycles(20, 15);
        cycle(1, 0, 1, 0, 0, 0);

        // Limit/periodic changes mid-run are ignored
        cycle(1, 1, 0, 0, 0, 6);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 1, i);
        // Restart from DONE
        cycle(1, 1, 0, 0, 0, 2);
        idle_cycles(5, 2);

        // Async reset during RUN at count 6
        cycle(1, 1, 0, 0, 0, 10);
        idle_cycles(6, 10);
        async_reset(2);
        cycle(1, 1, 0, 0, 0, 3);
        idle_cycles(6, 3);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r   = ($urandom_range(0, 199) == 0) ? 0 : 1;
            st  = ($urandom_range(0, 9) < 3) ? 1 : 0;
            sp  = ($urandom_range(0, 39) == 0) ? 1 : 0;
            hd  = ($urandom_range(0, 9) < 2) ? 1 : 0;
            per = int'($urandom_range(0, 1));
            lim = int'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) async_reset(1);
            cycle(r, st, sp, hd, per, lim);
        end

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have parameter NBITS, default 4, giving the counter width in bits.
REQ-002 clk  input  1  Single clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  Asynchronous, active-low reset; rst=0 SHALL force the reset state immediately.
REQ-004 start  input  1  Level-sampled request to begin a count sequence.
REQ-005 stop  input  1  Level-sampled abort; returns the block to idle.
REQ-006 hold  input  1  Level-sampled pause of a running sequence.
REQ-007 periodic  input  1  Mode: 1 = auto-restart at limit, 0 = one-shot; sampled with start.
REQ-008 limit  input  NBITS  Terminal count value; sampled with start.
REQ-009 count  output  NBITS  Current counter value, registered.
REQ-010 cnt_ena  output  1  Combinational advance strobe; high in any cycle where count advances or wraps on the next edge.
REQ-011 busy  output  1  High when state is RUN or HOLD.
REQ-012 done  output  1  Registered one-cycle pulse marking terminal count reached.
REQ-013 state  output  2  Encoded FSM state: IDLE=00, RUN=01, HOLD=10, DONE=11.

Function
REQ-014 In IDLE, start=1 and stop=0 SHALL cause: state<=RUN, count<=0, limit_q<=limit, mode_q<=periodic.
REQ-015 limit_q and mode_q SHALL be captured only on an accepted start; later changes to limit or periodic SHALL be ignored until the next accepted start.
REQ-016 cnt_ena SHALL equal (state==RUN) AND hold=0 AND stop=0.
REQ-017 In RUN with cnt_ena=1 and count!=limit_q, count SHALL increment by 1 at the edge.
REQ-018 In RUN with cnt_ena=1 and count==limit_q, done SHALL be 1 for exactly the following cycle.
REQ-019 At that same edge in one-shot mode, state SHALL go to DONE with count held at limit_q.
REQ-020 At that same edge in periodic mode, count SHALL go to 0 with state remaining RUN, giving a period of limit_q+1 cycles.
REQ-021 In RUN with hold=1 and stop=0, count SHALL freeze and state SHALL go to HOLD.
REQ-022 In HOLD, count SHALL stay frozen.
REQ-023 In HOLD, hold=0 and stop=0 SHALL return state to RUN; counting SHALL resume at the next edge with cnt_ena=1.
REQ-024 stop=1 SHALL have priority over start, hold and terminal count in every state: state<=IDLE, count<=0, done<=0.
REQ-025 In DONE, start=1 with stop=0 SHALL restart exactly as in REQ-014.
REQ-026 In DONE without start or stop, the block SHALL remain in DONE with count=limit_q.
REQ-027 start SHALL be ignored in RUN and HOLD.
REQ-028 With limit_q=0 in one-shot mode, done SHALL pulse after the first RUN cycle, then state SHALL go to DONE.
REQ-029 With limit_q=0 in periodic mode, done SHALL be high every cycle while cnt_ena=1.
REQ-030 limit=2^NBITS-1 SHALL be legal.
REQ-031 count SHALL never exceed limit_q and SHALL never wrap through 2^NBITS.
REQ-032 In IDLE, count SHALL be 0 and done SHALL be 0.
REQ-033 done SHALL be 0 in every cycle not covered by REQ-018.

Reset
REQ-034 While rst=0, the block SHALL hold: state=IDLE, count=0, done=0, busy=0, cnt_ena=0, limit_q=0, mode_q=0.
REQ-035 Reset asserted mid-sequence, in any state, SHALL abort immediately with no done pulse.
REQ-036 After rst returns to 1, the first rising clk edge SHALL be evaluated as normal IDLE behaviour.

Verification
REQ-037 The bench SHALL cover one-shot: limit=5, periodic=0, start pulse -> count 0,1,2,3,4,5; one done pulse; state=DONE with count held at 5; busy low.
REQ-038 The bench SHALL cover periodic: limit=3, periodic=1, start -> count 0,1,2,3,0,1,...; done every 4th cycle; busy held high.
REQ-039 The bench SHALL cover hold: NBITS=4, limit=9, hold=1 for 3 cycles at count=4 -> count frozen at 4, state=HOLD, cnt_ena=0; after release, resumes 5..9; done once.
REQ-040 The bench SHALL cover stop priority: start=1 and stop=1 in IDLE -> stays IDLE; stop=1 at count=7 in RUN -> next cycle IDLE, count=0, no done.
REQ-041 The bench SHALL cover boundaries: limit=0 one-shot -> done after one RUN cycle; limit=15 periodic -> wraps 15->0 with done; limit changed mid-run -> no effect.
REQ-042 The bench SHALL cover async reset: rst=0 driven between clk edges during RUN at count=6 -> outputs zero before the next edge; after release, start is accepted normally.
